// File: rtl/vtage_update_ctrl.sv
// vtage_update_ctrl: update scheduler for one VTAGE bank.
// Buffers commit groups in a small FIFO, issues non-conflicting lanes of the
// head group each cycle, and decodes them into registered bank update strobes.
// Optional periodic useful-counter sweep: define VTAGE_USEFUL_SWEEP_EN.
module vtage_update_ctrl #(
  parameter int P_NUM_PRED     = 2,
  parameter int P_NUM_ENTRIES  = 256,
  parameter int P_TAG_WIDTH    = 8,
  parameter int P_FIFO_DEPTH   = 4,
  parameter int P_RESET_PERIOD = 1024,
  localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES),
  localparam int LP_CNT_WIDTH   = $clog2(P_FIFO_DEPTH) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [P_NUM_PRED-1:0]                 cm_valid_i,
  output logic                                  cm_ready_o,
  input  logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]  cm_index_i,
  input  logic [P_NUM_PRED*P_TAG_WIDTH-1:0]     cm_tag_i,
  input  logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]  cm_value_i,
  input  logic [P_NUM_PRED-1:0]                 cm_hit_i,
  input  logic [P_NUM_PRED-1:0]                 cm_correct_i,
  input  logic [P_NUM_PRED-1:0]                 cm_alloc_i,
  output logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]  ud_index_o,
  output logic [P_NUM_PRED*P_TAG_WIDTH-1:0]     ud_tag_o,
  output logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]  ud_value_o,
  output logic [P_NUM_PRED-1:0]                 ud_incr_conf_o,
  output logic [P_NUM_PRED-1:0]                 ud_rst_conf_o,
  output logic [P_NUM_PRED-1:0]                 ud_incr_use_o,
  output logic [P_NUM_PRED-1:0]                 ud_decr_use_o,
  output logic [P_NUM_PRED-1:0]                 ud_rst_use_o,
  output logic [P_NUM_PRED-1:0]                 ud_load_tag_o,
  output logic [P_NUM_PRED-1:0]                 ud_load_value_o,
  output logic [LP_CNT_WIDTH-1:0]               fifo_count_o,
  output logic                                  sweep_busy_o
);

  localparam int NP = P_NUM_PRED;
  localparam int IW = LP_INDEX_WIDTH;
  localparam int TW = P_TAG_WIDTH;
  localparam int PW = $clog2(P_FIFO_DEPTH);

  // FIFO storage
  logic [NP-1:0]    f_valid_r   [P_FIFO_DEPTH];
  logic [NP-1:0]    f_hit_r     [P_FIFO_DEPTH];
  logic [NP-1:0]    f_correct_r [P_FIFO_DEPTH];
  logic [NP-1:0]    f_alloc_r   [P_FIFO_DEPTH];
  logic [NP*IW-1:0] f_index_r   [P_FIFO_DEPTH];
  logic [NP*IW-1:0] f_value_r   [P_FIFO_DEPTH];
  logic [NP*TW-1:0] f_tag_r     [P_FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [LP_CNT_WIDTH-1:0] count_r;

  // Head issue signals
  logic             head_valid_s;
  logic [NP-1:0]    head_pend_s;
  logic [NP*IW-1:0] head_index_s;
  logic [NP-1:0]    blocked_s;
  logic [NP-1:0]    issue_s;
  logic [NP-1:0]    left_s;
  logic             pop_s;
  logic             push_s;
  logic             idle_s;

  // Next-value decode of the output registers
  logic [NP*IW-1:0] nxt_index_s;
  logic [NP*TW-1:0] nxt_tag_s;
  logic [NP*IW-1:0] nxt_value_s;
  logic [NP-1:0]    nxt_ic_s, nxt_rc_s, nxt_iu_s, nxt_du_s, nxt_ru_s, nxt_lt_s, nxt_lv_s;

  // Sweep control
  logic             sweep_load_s;
  logic [IW-1:0]    sweep_next_base_s;

  assign fifo_count_o = count_r;
  assign cm_ready_o   = idle_s && (count_r < LP_CNT_WIDTH'(P_FIFO_DEPTH));
  assign push_s       = (|cm_valid_i) && cm_ready_o;

  // Head lane selection: a pending lane issues unless a lower pending lane hits the same entry
  always_comb begin
    head_valid_s = (count_r != {LP_CNT_WIDTH{1'b0}});
    head_pend_s  = head_valid_s ? f_valid_r[rd_ptr_r] : {NP{1'b0}};
    head_index_s = f_index_r[rd_ptr_r];
    blocked_s    = {NP{1'b0}};
    issue_s      = {NP{1'b0}};
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < p; q++) begin
        blocked_s[p] = blocked_s[p] |
                       (head_pend_s[q] & (head_index_s[q*IW +: IW] == head_index_s[p*IW +: IW]));
      end
      issue_s[p] = head_pend_s[p] & ~blocked_s[p];
    end
    left_s = head_pend_s & ~issue_s;
    pop_s  = head_valid_s && (left_s == {NP{1'b0}});
  end

  // Translate each issued lane's hit/correct/alloc outcome into bank strobes
  always_comb begin
    nxt_index_s = {(NP*IW){1'b0}};
    nxt_tag_s   = {(NP*TW){1'b0}};
    nxt_value_s = {(NP*IW){1'b0}};
    nxt_ic_s = {NP{1'b0}}; nxt_rc_s = {NP{1'b0}}; nxt_iu_s = {NP{1'b0}};
    nxt_du_s = {NP{1'b0}}; nxt_ru_s = {NP{1'b0}}; nxt_lt_s = {NP{1'b0}};
    nxt_lv_s = {NP{1'b0}};
    for (int p = 0; p < NP; p++) begin
      if (issue_s[p]) begin
        nxt_index_s[p*IW +: IW] = head_index_s[p*IW +: IW];
        nxt_tag_s[p*TW +: TW]   = f_tag_r[rd_ptr_r][p*TW +: TW];
        nxt_value_s[p*IW +: IW] = f_value_r[rd_ptr_r][p*IW +: IW];
        nxt_ic_s[p] =  f_hit_r[rd_ptr_r][p] &  f_correct_r[rd_ptr_r][p];
        nxt_iu_s[p] =  f_hit_r[rd_ptr_r][p] &  f_correct_r[rd_ptr_r][p];
        nxt_du_s[p] =  f_hit_r[rd_ptr_r][p] & ~f_correct_r[rd_ptr_r][p];
        nxt_lt_s[p] = ~f_hit_r[rd_ptr_r][p] &  f_alloc_r[rd_ptr_r][p];
        nxt_ru_s[p] = ~f_hit_r[rd_ptr_r][p] &  f_alloc_r[rd_ptr_r][p];
        nxt_rc_s[p] = nxt_du_s[p] | nxt_lt_s[p];
        nxt_lv_s[p] = nxt_du_s[p] | nxt_lt_s[p];
      end else begin
        nxt_ic_s[p] = 1'b0;
        nxt_rc_s[p] = 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy and per-group pending lane bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {LP_CNT_WIDTH{1'b0}};
      for (int i = 0; i < P_FIFO_DEPTH; i++) begin
        f_valid_r[i] <= {NP{1'b0}};
      end
    end else begin
      if (head_valid_s) begin
        f_valid_r[rd_ptr_r] <= left_s;
      end
      if (push_s) begin
        f_valid_r[wr_ptr_r] <= cm_valid_i;
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LP_CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - LP_CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO payload capture; contents are only meaningful behind a valid pointer
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      f_hit_r[wr_ptr_r]     <= cm_hit_i;
      f_correct_r[wr_ptr_r] <= cm_correct_i;
      f_alloc_r[wr_ptr_r]   <= cm_alloc_i;
      f_index_r[wr_ptr_r]   <= cm_index_i;
      f_value_r[wr_ptr_r]   <= cm_value_i;
      f_tag_r[wr_ptr_r]     <= cm_tag_i;
    end
  end

  // Registered bank update outputs: sweep step, decoded issue, or idle zeros
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ud_index_o <= {(NP*IW){1'b0}};
      ud_tag_o   <= {(NP*TW){1'b0}};
      ud_value_o <= {(NP*IW){1'b0}};
      ud_incr_conf_o <= {NP{1'b0}}; ud_rst_conf_o <= {NP{1'b0}};
      ud_incr_use_o  <= {NP{1'b0}}; ud_decr_use_o <= {NP{1'b0}};
      ud_rst_use_o   <= {NP{1'b0}}; ud_load_tag_o <= {NP{1'b0}};
      ud_load_value_o <= {NP{1'b0}};
    end else if (sweep_load_s) begin
      for (int p = 0; p < NP; p++) begin
        ud_index_o[p*IW +: IW] <= sweep_next_base_s + IW'(p);
      end
      ud_tag_o   <= {(NP*TW){1'b0}};
      ud_value_o <= {(NP*IW){1'b0}};
      ud_incr_conf_o <= {NP{1'b0}}; ud_rst_conf_o <= {NP{1'b0}};
      ud_incr_use_o  <= {NP{1'b0}}; ud_decr_use_o <= {NP{1'b0}};
      ud_rst_use_o   <= {NP{1'b1}}; ud_load_tag_o <= {NP{1'b0}};
      ud_load_value_o <= {NP{1'b0}};
    end else begin
      ud_index_o <= nxt_index_s;
      ud_tag_o   <= nxt_tag_s;
      ud_value_o <= nxt_value_s;
      ud_incr_conf_o <= nxt_ic_s; ud_rst_conf_o <= nxt_rc_s;
      ud_incr_use_o  <= nxt_iu_s; ud_decr_use_o <= nxt_du_s;
      ud_rst_use_o   <= nxt_ru_s; ud_load_tag_o <= nxt_lt_s;
      ud_load_value_o <= nxt_lv_s;
    end
  end

`ifdef VTAGE_USEFUL_SWEEP_EN
  localparam int LP_PER_WIDTH = $clog2(P_RESET_PERIOD + 1);
  localparam logic [LP_PER_WIDTH-1:0] LP_PERIOD    = LP_PER_WIDTH'(P_RESET_PERIOD);
  localparam logic [IW-1:0]           LP_LAST_BASE = IW'(P_NUM_ENTRIES - P_NUM_PRED);
  localparam logic [IW-1:0]           LP_STEP      = IW'(P_NUM_PRED);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_SWEEP = 2'b10
  } state_t;

  state_t                  state_r;
  logic [LP_PER_WIDTH-1:0] period_r;
  logic [IW-1:0]           base_r;
  logic                    iss_any_r;
  logic                    drain_done_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign sweep_busy_o = (state_r != ST_IDLE);

  // Sweep step selection: first step on leaving DRAIN, then advance until the last base
  always_comb begin
    drain_done_s      = (count_r == {LP_CNT_WIDTH{1'b0}}) && !iss_any_r;
    sweep_load_s      = 1'b0;
    sweep_next_base_s = {IW{1'b0}};
    case (state_r)
      ST_DRAIN: begin
        sweep_load_s      = drain_done_s;
        sweep_next_base_s = {IW{1'b0}};
      end
      ST_SWEEP: begin
        sweep_load_s      = (base_r != LP_LAST_BASE);
        sweep_next_base_s = base_r + LP_STEP;
      end
      default: begin
        sweep_load_s      = 1'b0;
        sweep_next_base_s = {IW{1'b0}};
      end
    endcase
  end

  // Tracks whether the issue registers currently hold a retiring lane
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_any_r <= 1'b0;
    end else begin
      iss_any_r <= (|issue_s) && !sweep_load_s;
    end
  end

  // Sweep FSM with period counter and sweep base
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      period_r <= {LP_PER_WIDTH{1'b0}};
      base_r   <= {IW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (period_r == LP_PERIOD) begin
            state_r  <= ST_DRAIN;
            period_r <= push_s ? LP_PER_WIDTH'(1) : {LP_PER_WIDTH{1'b0}};
          end else if (push_s) begin
            period_r <= period_r + LP_PER_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            state_r <= ST_SWEEP;
            base_r  <= {IW{1'b0}};
          end
        end
        ST_SWEEP: begin
          if (base_r == LP_LAST_BASE) begin
            state_r <= ST_IDLE;
            base_r  <= {IW{1'b0}};
          end else begin
            base_r <= sweep_next_base_s;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          base_r   <= {IW{1'b0}};
        end
      endcase
    end
  end
`else
  assign idle_s            = 1'b1;
  assign sweep_busy_o      = 1'b0;
  assign sweep_load_s      = 1'b0;
  assign sweep_next_base_s = {IW{1'b0}};
`endif

endmodule

// File: tb/tb_vtage_update_ctrl.sv
// Testbench for vtage_update_ctrl: directed cases plus randomized traffic
// checked every cycle against a queue-based behavioural model.
// Sweep checks are built when VTAGE_USEFUL_SWEEP_EN is defined.
module tb_vtage_update_ctrl;

`ifdef VTAGE_USEFUL_SWEEP_EN
  localparam int NE = 16;
  localparam int RP = 4;
  localparam int TARGET = 600;
`else
  localparam int NE = 256;
  localparam int RP = 1024;
  localparam int TARGET = 2000;
`endif
  localparam int NP = 2;
  localparam int TW = 8;
  localparam int FD = 4;
  localparam int IW = $clog2(NE);
  localparam int CW = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    cm_valid = '0, cm_hit = '0, cm_correct = '0, cm_alloc = '0;
  logic [NP*IW-1:0] cm_index = '0, cm_value = '0;
  logic [NP*TW-1:0] cm_tag = '0;
  logic             cm_ready_o;
  logic [NP*IW-1:0] ud_index_o, ud_value_o;
  logic [NP*TW-1:0] ud_tag_o;
  logic [NP-1:0]    ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o;
  logic [NP-1:0]    ud_rst_use_o, ud_load_tag_o, ud_load_value_o;
  logic [CW-1:0]    fifo_count_o;
  logic             sweep_busy_o;

  vtage_update_ctrl #(
    .P_NUM_PRED(NP), .P_NUM_ENTRIES(NE), .P_TAG_WIDTH(TW),
    .P_FIFO_DEPTH(FD), .P_RESET_PERIOD(RP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cm_valid_i(cm_valid), .cm_ready_o(cm_ready_o),
    .cm_index_i(cm_index), .cm_tag_i(cm_tag), .cm_value_i(cm_value),
    .cm_hit_i(cm_hit), .cm_correct_i(cm_correct), .cm_alloc_i(cm_alloc),
    .ud_index_o(ud_index_o), .ud_tag_o(ud_tag_o), .ud_value_o(ud_value_o),
    .ud_incr_conf_o(ud_incr_conf_o), .ud_rst_conf_o(ud_rst_conf_o),
    .ud_incr_use_o(ud_incr_use_o), .ud_decr_use_o(ud_decr_use_o),
    .ud_rst_use_o(ud_rst_use_o), .ud_load_tag_o(ud_load_tag_o),
    .ud_load_value_o(ud_load_value_o),
    .fifo_count_o(fifo_count_o), .sweep_busy_o(sweep_busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [NP-1:0]    pend;
    logic [NP-1:0]    hit;
    logic [NP-1:0]    cor;
    logic [NP-1:0]    alc;
    logic [NP*IW-1:0] idx;
    logic [NP*IW-1:0] val;
    logic [NP*TW-1:0] tag;
  } grp_t;

  grp_t q[$];
  int   mode = 0;       // 0 normal, 1 draining, 2 sweeping
  int   per = 0;
  int   step = 0;
  bit   prev_iss = 1'b0;
  bit   started = 1'b0;
  int   n_acc = 0;

  logic [NP*IW-1:0] e_index, e_value;
  logic [NP*TW-1:0] e_tag;
  logic [NP-1:0]    e_ic, e_rc, e_iu, e_du, e_ru, e_lt, e_lv;
  logic [CW-1:0]    e_count;
  logic             e_busy, e_ready;

  task automatic clear_exp();
    e_index = '0; e_value = '0; e_tag = '0;
    e_ic = '0; e_rc = '0; e_iu = '0; e_du = '0; e_ru = '0; e_lt = '0; e_lv = '0;
  endtask

  task automatic model_step();
    grp_t h;
    grp_t g;
    logic [NP-1:0] iss;
    bit rdy, acc;
    int qsz0;
    if (rst) begin
      q.delete(); mode = 0; per = 0; step = 0; prev_iss = 1'b0; started = 1'b1;
      clear_exp();
      e_count = '0; e_busy = 1'b0; e_ready = 1'b1;
      return;
    end
    if (!started) return;
    qsz0 = q.size();
    rdy  = (mode == 0) && (q.size() < FD);
    acc  = (cm_valid != '0) && rdy;
    clear_exp();
    iss  = '0;
    if (q.size() > 0) begin
      h = q[0];
      for (int p = 0; p < NP; p++) begin
        iss[p] = h.pend[p];
        for (int r = 0; r < p; r++)
          if (h.pend[r] && h.idx[r*IW +: IW] == h.idx[p*IW +: IW]) iss[p] = 1'b0;
        if (iss[p]) begin
          e_index[p*IW +: IW] = h.idx[p*IW +: IW];
          e_value[p*IW +: IW] = h.val[p*IW +: IW];
          e_tag[p*TW +: TW]   = h.tag[p*TW +: TW];
          if (h.hit[p] && h.cor[p]) begin e_ic[p] = 1; e_iu[p] = 1; end
          else if (h.hit[p]) begin e_rc[p] = 1; e_du[p] = 1; e_lv[p] = 1; end
          else if (h.alc[p]) begin e_lt[p] = 1; e_lv[p] = 1; e_rc[p] = 1; e_ru[p] = 1; end
        end
      end
      h.pend = h.pend & ~iss;
      if (h.pend == '0) void'(q.pop_front());
      else q[0] = h;
    end
`ifdef VTAGE_USEFUL_SWEEP_EN
    case (mode)
      0: begin
        if (per == RP) begin mode = 1; per = acc ? 1 : 0; end
        else if (acc) per++;
      end
      1: begin
        if (qsz0 == 0 && !prev_iss) begin mode = 2; step = 0; end
      end
      default: begin
        if (step == NE/NP - 1) begin mode = 0; step = 0; end
        else step++;
      end
    endcase
    if (mode == 2) begin
      clear_exp();
      e_ru = '1;
      for (int p = 0; p < NP; p++) e_index[p*IW +: IW] = IW'(step*NP + p);
    end
`endif
    if (acc) begin
      g.pend = cm_valid; g.hit = cm_hit; g.cor = cm_correct; g.alc = cm_alloc;
      g.idx = cm_index; g.val = cm_value; g.tag = cm_tag;
      q.push_back(g);
      n_acc++;
    end
    prev_iss = (iss != '0);
    e_count = CW'(q.size());
    e_busy  = (mode != 0);
    e_ready = (mode == 0) && (q.size() < FD);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare DUT against the model every cycle once reset has been seen
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("ud_index", ud_index_o, e_index);
      check("ud_tag", ud_tag_o, e_tag);
      check("ud_value", ud_value_o, e_value);
      check("strobes", {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                        ud_rst_use_o, ud_load_tag_o, ud_load_value_o},
                       {e_ic, e_rc, e_iu, e_du, e_ru, e_lt, e_lv});
      check("fifo_count", fifo_count_o, e_count);
      check("sweep_busy", sweep_busy_o, e_busy);
      check("cm_ready", cm_ready_o, e_ready);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    cm_valid = '0; cm_hit = '0; cm_correct = '0; cm_alloc = '0;
    cm_index = '0; cm_value = '0; cm_tag = '0;
  endtask

  task automatic set_lane(input int p, input int idx, input int tag, input int val,
                          input bit h, input bit c, input bit a);
    cm_valid[p] = 1'b1;
    cm_index[p*IW +: IW] = IW'(idx);
    cm_tag[p*TW +: TW]   = TW'(tag);
    cm_value[p*IW +: IW] = IW'(val);
    cm_hit[p] = h; cm_correct[p] = c; cm_alloc[p] = a;
  endtask

  logic [IW-1:0] val77;
  logic [NP*IW-1:0] ei;
  int bound;
  bit flag;

  initial begin
    val77 = IW'(8'h77);
    clear_in();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", cm_ready_o, 1);
    check("reset_count", fifo_count_o, 0);
    check("reset_strobes", {ud_incr_conf_o, ud_rst_use_o, ud_load_value_o, ud_index_o}, 0);
    check("reset_busy", sweep_busy_o, 0);

    // single hit-correct on lane 0, index 5
    set_lane(0, 5, 8'h11, 3, 1'b1, 1'b1, 1'b0);
    @(negedge clk); clear_in();
    @(negedge clk);
    check("single_index0", ud_index_o[IW-1:0], 5);
    check("single_strobes", {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                             ud_rst_use_o, ud_load_tag_o, ud_load_value_o},
                            14'b01_00_01_00_00_00_00);

    // same-index conflict
    set_lane(0, 9, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    set_lane(1, 9, 8'h3C, 8'h77, 1'b0, 1'b0, 1'b1);
    @(negedge clk); clear_in();
    @(negedge clk);
    check("conflict_c1_index0", ud_index_o[IW-1:0], 9);
    check("conflict_c1_strobes", {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                                  ud_rst_use_o, ud_load_tag_o, ud_load_value_o},
                                 14'b00_01_00_01_00_00_01);
    @(negedge clk);
    check("conflict_c2_strobes", {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                                  ud_rst_use_o, ud_load_tag_o, ud_load_value_o},
                                 14'b00_10_00_00_10_10_10);
    check("conflict_c2_tag1", ud_tag_o[2*TW-1:TW], 8'h3C);
    check("conflict_c2_value1", ud_value_o[2*IW-1:IW], val77);
    check("conflict_c2_index1", ud_index_o[2*IW-1:IW], 9);
    check("conflict_count", fifo_count_o, 0);
    @(negedge clk);

`ifndef VTAGE_USEFUL_SWEEP_EN
    // backpressure with conflicting lanes
    flag = 1'b0;
    for (int t = 0; t < 10; t++) begin
      set_lane(0, 7, t, t, 1'b1, 1'b1, 1'b0);
      set_lane(1, 7, t + 8'h80, t, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (fifo_count_o == CW'(FD) && !cm_ready_o) flag = 1'b1;
    end
    clear_in();
    check("bp_full_not_ready", flag, 1);
    repeat (12) @(negedge clk);
    check("bp_drained", fifo_count_o, 0);
`else
    // useful sweep after RP accepted groups
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < RP; i++) begin
      set_lane(0, i + 1, i, i, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
    end
    clear_in();
    flag = 1'b0; bound = 0;
    while (ud_rst_use_o != 2'b11 && bound < 100) begin
      if (!cm_ready_o && sweep_busy_o) flag = 1'b1;
      @(negedge clk); bound++;
    end
    check("sweep_start_in_time", bound < 100, 1);
    check("drain_ready_low", flag, 1);
    for (int k = 0; k < NE/NP; k++) begin
      ei[IW-1:0] = IW'(2*k); ei[2*IW-1:IW] = IW'(2*k + 1);
      check("sweep_rst_use", ud_rst_use_o, 2'b11);
      check("sweep_index", ud_index_o, ei);
      check("sweep_ready_low", cm_ready_o, 0);
      @(negedge clk);
    end
    check("post_sweep_rst_use", ud_rst_use_o, 0);
    check("post_sweep_ready", cm_ready_o, 1);
    check("post_sweep_busy", sweep_busy_o, 0);

    // reset on the 3rd sweep cycle
    for (int i = 0; i < RP; i++) begin
      set_lane(0, i + 2, i, i, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    clear_in();
    bound = 0;
    while (ud_rst_use_o != 2'b11 && bound < 100) begin
      @(negedge clk); bound++;
    end
    check("sweep2_start_in_time", bound < 100, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_rst_strobes", {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
                                   ud_rst_use_o, ud_load_tag_o, ud_load_value_o}, 0);
    check("midsweep_rst_busy", sweep_busy_o, 0);
    check("midsweep_rst_count", fifo_count_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midsweep_ready_after", cm_ready_o, 1);
`endif

    // randomized traffic
    flag = 1'b0;
    bound = 0;
    while (n_acc < TARGET + 8 && bound < 40000) begin
      clear_in();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) != 0)
          set_lane(p, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, NE - 1),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      if (sweep_busy_o) flag = 1'b1;
      bound++;
    end
    rst = 1'b0;
    clear_in();
    check("random_accept_target", n_acc >= TARGET, 1);
`ifndef VTAGE_USEFUL_SWEEP_EN
    check("no_sweep_busy", flag, 0);
`endif
    repeat (40) @(negedge clk);
    check("final_count", fifo_count_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vtage_update_ctrl.md
# vtage_update_ctrl

Update scheduler for one VTAGE bank. Buffers commit-time training requests, decodes them into the bank's per-lane update strobes, and serialises lanes that target the same entry within a group. Optionally runs a periodic sweep that resets the useful counters of every entry. Sits between the commit/training logic and the `ud_*` port group of `vtage_bank`.

## Interface
- `P_NUM_PRED`, 2: lanes per commit group; equals the bank's `P_NUM_PRED`.
- `P_NUM_ENTRIES`, 256: bank entries; power of two, a multiple of `P_NUM_PRED`. `LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)`.
- `P_TAG_WIDTH`, 8: tag width.
- `P_FIFO_DEPTH`, 4: commit groups buffered; power of two, ≥2.
- `P_RESET_PERIOD`, 1024: accepted groups between useful sweeps; ≥1.

Ports:
- `clk_i`, in, 1: clock; single clock domain.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `cm_valid_i`, in, `P_NUM_PRED`: per-lane commit request valid.
- `cm_ready_o`, out, 1: group accepted when `|cm_valid_i && cm_ready_o`.
- `cm_index_i`, in, `P_NUM_PRED×LP_INDEX_WIDTH`: entry index per lane.
- `cm_tag_i`, in, `P_NUM_PRED×P_TAG_WIDTH`: tag per lane.
- `cm_value_i`, in, `P_NUM_PRED×LP_INDEX_WIDTH`: committed value per lane.
- `cm_hit_i`, in, `P_NUM_PRED`: bank tag hit at prediction time.
- `cm_correct_i`, in, `P_NUM_PRED`: prediction was correct.
- `cm_alloc_i`, in, `P_NUM_PRED`: on a miss, allocate the entry.
- `ud_index_o`, `ud_tag_o`, `ud_value_o`, out, per lane: update index, tag and value driven to the bank.
- `ud_incr_conf_o`, `ud_rst_conf_o`, `ud_incr_use_o`, `ud_decr_use_o`, `ud_rst_use_o`, `ud_load_tag_o`, `ud_load_value_o`, out, `P_NUM_PRED` each: update strobes.
- `fifo_count_o`, out, `$clog2(P_FIFO_DEPTH)+1`: groups currently buffered.
- `sweep_busy_o`, out, 1: high when the state is DRAIN or SWEEP.

## Operation
- **FIFO.** Accepted groups are written to the tail of a `P_FIFO_DEPTH` FIFO. Lane valids are stored with the group.
- **Ready.** `cm_ready_o = (state==IDLE) && (count < P_FIFO_DEPTH)`. It is combinational from registers only, with no dependency on `cm_valid_i`.
- **Issue.** Each cycle, the head group issues every pending lane `p` whose index does not equal the index of any lower-numbered pending lane.
  - Issued lanes clear their pending bit.
  - The head is popped in the cycle its last pending lane issues.
  - A group whose lanes all target one index therefore takes `P_NUM_PRED` cycles.
- **Decode per issued lane:**
  - hit & correct: `incr_conf`, `incr_use`.
  - hit & !correct: `rst_conf`, `decr_use`, `load_value`.
  - !hit & alloc: `load_tag`, `load_value`, `rst_conf`, `rst_use`.
  - !hit & !alloc: lane is consumed with no strobes.
- **Idle outputs.** Lanes not issuing drive all strobes 0 and `ud_index/tag/value` as 0.
- **FSM states:**
  - IDLE: normal operation.
  - DRAIN: `cm_ready_o=0`; the FIFO continues issuing. Moves to SWEEP when the FIFO is empty and the last issue register has retired.
  - SWEEP: issues `ud_rst_use_o` on all lanes with `ud_index_o[p] = base + p`, where base starts at 0 and steps by `P_NUM_PRED`. After the last step (base = `P_NUM_ENTRIES − P_NUM_PRED`), returns to IDLE.
- **Period counter.**
  - Increments once per accepted group and saturates at `P_RESET_PERIOD`.
  - Reaching `P_RESET_PERIOD` moves IDLE to DRAIN and clears the counter.
  - A group accepted in the same cycle as the transition is counted toward the next period.
- **Simultaneous push and pop** at full: no push is possible because ready is low at full. At any other count, push and pop in the same cycle leave the count unchanged.

## Timing
- **Reset values.** All strobes 0, `ud_index/tag/value_o` 0, `fifo_count_o` 0, `sweep_busy_o` 0, state IDLE, counter 0, sweep base 0. `cm_ready_o` is 1 in the first cycle after reset deasserts.
- **Latency.** A group accepted on edge N is at the FIFO head in cycle N+1. Its issue registers load on edge N+1, so strobes are visible during cycle N+2. Sustained throughput is one conflict-free group per cycle.
- **Registered outputs.** All `ud_*` outputs come from registers; none depend combinationally on `cm_*` inputs.
- **Sweep length.** SWEEP lasts exactly `P_NUM_ENTRIES/P_NUM_PRED` cycles of `ud_rst_use_o` strobes. `sweep_busy_o` falls on the edge after the last strobe cycle.
- **Reset mid-operation.** `rst_i` in any state:
  - flushes the FIFO, including any pending lanes;
  - aborts the sweep;
  - zeroes the strobes on the next edge.

## Configuration
- `VTAGE_USEFUL_SWEEP_EN` defined: the period counter, DRAIN and SWEEP states are present as described.
- Not defined: no counter and no sweep logic. The state is always IDLE, `sweep_busy_o` is tied to 0, and `cm_ready_o` depends on FIFO occupancy only.

## Test plan
- **Single hit-correct.** Lane 0 with index 5, hit=1, correct=1 accepted on edge N → in cycle N+2, `ud_index_o[0]=5`, `incr_conf[0]=incr_use[0]=1`, all other strobes 0.
- **Same-index conflict.** Both lanes index 9: lane 0 hit/wrong, lane 1 miss with alloc, tag 0x3C, value 0x77 → cycle N+2 issues lane 0 only (`rst_conf`, `decr_use`, `load_value`). Cycle N+3 issues lane 1 (`load_tag` with tag 0x3C, `load_value` with value 0x77, `rst_conf`, `rst_use`). `fifo_count_o` reaches 0 after edge N+3.
- **Backpressure.** Hold `cm_valid_i=2'b11` with conflicting indices for 10 cycles → `cm_ready_o` drops once `fifo_count_o=4`. No group is lost or duplicated; issue order matches acceptance order.
- **Sweep** (macro defined, `P_RESET_PERIOD=4`, `P_NUM_ENTRIES=16`) → after 4 accepted groups, `cm_ready_o=0` and DRAIN empties the FIFO. Then 8 consecutive cycles follow with `ud_rst_use_o=2'b11` and indices (0,1), (2,3), … (14,15), after which `cm_ready_o=1`.
- **Reset mid-sweep.** Assert `rst_i` on the 3rd sweep cycle → next cycle all strobes are 0, `sweep_busy_o=0`, `fifo_count_o=0`, and `cm_ready_o=1` after deassertion.
- **Macro undefined.** Accept 2000 groups → `sweep_busy_o` stays 0 and `ud_rst_use_o` pulses only for miss-allocate lanes.
